// File: rtl/llr_max_accum.sv
// Per-bit LLR accumulator: tracks the max path metric per hypothesis over M beats and emits max1 - max0.
// Optional feature: define LLR_SAT_EN to clip the result to the N-bit signed range.
module llr_max_accum #(
  parameter int N = 12,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_metric,
  input  logic         in_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out_llr
);

  localparam int CW = $clog2(M);
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]          state;
  logic [N-1:0]        max0;
  logic [N-1:0]        max1;
  logic [CW-1:0]       cnt;
  logic                accept;
  logic                last_beat;
  logic [N-1:0]        max0_nxt;
  logic [N-1:0]        max1_nxt;
  logic signed [N:0]   diff;
  logic signed [N:0]   llr_nxt;

  assign accept    = (state == ACCUM) && in_valid && in_ready;
  assign last_beat = accept && (cnt == LAST);

  // Running maxima including the beat on this edge; ties keep the stored value.
  always_comb begin
    max0_nxt = max0;
    max1_nxt = max1;
    if (accept) begin
      if (in_bit == 1'b0) begin
        if (in_metric > max0) max0_nxt = in_metric;
      end else begin
        if (in_metric > max1) max1_nxt = in_metric;
      end
    end
  end

  assign diff = $signed({1'b0, max1_nxt}) - $signed({1'b0, max0_nxt});

`ifdef LLR_SAT_EN
  localparam logic signed [N:0] SAT_HI = {2'b00, {(N-1){1'b1}}};
  localparam logic signed [N:0] SAT_LO = {2'b11, {(N-1){1'b0}}};

  always_comb begin
    llr_nxt = diff;
    if (diff > SAT_HI)      llr_nxt = SAT_HI;
    else if (diff < SAT_LO) llr_nxt = SAT_LO;
  end
`else
  assign llr_nxt = diff;
`endif

  // in_ready is raised one edge after reset release and dropped while a result is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_llr   <= '0;
      max0      <= '0;
      max1      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (last_beat) begin
            out_llr   <= llr_nxt;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            state     <= HOLD;
            max0      <= '0;
            max1      <= '0;
            cnt       <= '0;
          end else begin
            in_ready <= 1'b1;
            max0     <= max0_nxt;
            max1     <= max1_nxt;
            if (accept) cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_llr_max_accum.sv
// Self-checking bench for llr_max_accum: directed vector table, handshake/reset sequences and random groups.
module tb_llr_max_accum;

  localparam int N = 12;
  localparam int M = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_metric;
  logic         in_bit;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out_llr;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_acc = 0;

  typedef struct {
    logic [7:0][11:0] met;
    logic [7:0]       b;
    int               exp_llr;
  } vec_t;

  vec_t vecs [5];

  llr_max_accum #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_metric (in_metric),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_llr   (out_llr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: max per hypothesis over the group (empty hypothesis counts as 0), then max1 - max0.
  function automatic int model(input logic [7:0][11:0] met, input logic [7:0] b);
    int m0 = 0;
    int m1 = 0;
    int d;
    for (int i = 0; i < M; i++) begin
      if (b[i]) m1 = (int'(met[i]) > m1) ? int'(met[i]) : m1;
      else      m0 = (int'(met[i]) > m0) ? int'(met[i]) : m0;
    end
    d = m1 - m0;
`ifdef LLR_SAT_EN
    if (d > 2047)  d = 2047;
    if (d < -2048) d = -2048;
`endif
    return d;
  endfunction

  // Entered and left at a falling edge; drives beats until nbeats have been accepted.
  task automatic applyStimulus(input logic [7:0][11:0] met, input logic [7:0] b,
                               input int nbeats, input bit gapped);
    int  idx = 0;
    int  tries = 0;
    bit  acc;
    while (idx < nbeats && tries < 200) begin
      in_valid  = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      in_metric = in_valid ? met[idx] : 12'($urandom_range(0, 4095));
      in_bit    = in_valid ? b[idx] : 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        if (idx == 0) first_acc = cyc;
        idx++;
      end
      tries++;
    end
    if (idx < nbeats) checkOutput("beat_timeout", idx, nbeats);
    in_valid = 1'b0;
  endtask

  // Checks the result presented right after the last accepting edge, holding out_ready low for hold cycles.
  task automatic checkResult(input string name, input int exp, input int hold);
    checkOutput($sformatf("%s_valid", name), int'(out_valid), 1);
    checkOutput($sformatf("%s_llr", name), int'($signed(out_llr)), exp);
    checkOutput($sformatf("%s_inready", name), int'(in_ready), 0);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_metric = 12'd4095;
    in_bit    = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_hold_valid", name), int'(out_valid), 1);
      checkOutput($sformatf("%s_hold_llr", name), int'($signed(out_llr)), exp);
      checkOutput($sformatf("%s_hold_inready", name), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput($sformatf("%s_done_valid", name), int'(out_valid), 0);
    checkOutput($sformatf("%s_done_inready", name), int'(in_ready), 1);
    in_valid = 1'b0;
  endtask

  initial begin
    int f1;
    logic [7:0][11:0] rmet;
    logic [7:0]       rb;

    vecs[0].met = {12'd99, 12'd5, 12'd3, 12'd40, 12'd100, 12'd40, 12'd7, 12'd10};
    vecs[0].b   = 8'b1010_1010;
    vecs[0].exp_llr = 60;
    vecs[1].met = {12'd1500, 12'd7, 12'd2000, 12'd0, 12'd1999, 12'd5, 12'd2000, 12'd100};
    vecs[1].b   = 8'b0000_0000;
    vecs[1].exp_llr = -2000;
    vecs[2].met = {12'd60, 12'd50, 12'd40, 12'd30, 12'd4095, 12'd20, 12'd10, 12'd4095};
    vecs[2].b   = 8'b1111_1111;
    vecs[3].met = {8{12'd4095}};
    vecs[3].b   = 8'b1010_1010;
    vecs[3].exp_llr = 0;
    vecs[4].met = {12'd0, 12'd0, 12'd0, 12'd9, 12'd0, 12'd300, 12'd0, 12'd4095};
    vecs[4].b   = 8'b1010_1010;
`ifdef LLR_SAT_EN
    vecs[2].exp_llr = 2047;
    vecs[4].exp_llr = -2048;
`else
    vecs[2].exp_llr = 4095;
    vecs[4].exp_llr = -4095;
`endif

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_metric = '0;
    in_bit = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_inready", int'(in_ready), 0);
    checkOutput("reset_outvalid", int'(out_valid), 0);
    checkOutput("reset_llr", int'($signed(out_llr)), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release_inready", int'(in_ready), 1);

    $display("[TB] directed vector table");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].met, vecs[i].b, M, 1'b0);
      checkResult($sformatf("vec%0d", i), vecs[i].exp_llr, 0);
    end

    $display("[TB] back-to-back throughput");
    applyStimulus(vecs[0].met, vecs[0].b, M, 1'b0);
    f1 = first_acc;
    checkResult("tput_a", 60, 0);
    applyStimulus(vecs[0].met, vecs[0].b, M, 1'b0);
    checkOutput("tput_period", first_acc - f1, M + 1);
    checkResult("tput_b", 60, 0);

    $display("[TB] backpressure");
    applyStimulus(vecs[1].met, vecs[1].b, M, 1'b0);
    checkResult("bp", -2000, 5);
    applyStimulus(vecs[0].met, vecs[0].b, M, 1'b0);
    checkResult("bp_next", 60, 0);

    $display("[TB] gapped input");
    applyStimulus(vecs[0].met, vecs[0].b, M, 1'b1);
    checkResult("gapped", 60, 0);

    $display("[TB] reset mid-group");
    applyStimulus(vecs[4].met, vecs[4].b, M, 1'b0);
    checkResult("pre_rst", vecs[4].exp_llr, 0);
    applyStimulus(vecs[2].met, vecs[2].b, 5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_inready", int'(in_ready), 0);
    checkOutput("midrst_outvalid", int'(out_valid), 0);
    checkOutput("midrst_llr", int'($signed(out_llr)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("postrst_inready0", int'(in_ready), 0);
    @(negedge clk);
    checkOutput("postrst_inready1", int'(in_ready), 1);
    applyStimulus(vecs[0].met, vecs[0].b, M, 1'b0);
    checkResult("postrst", 60, 0);

    $display("[TB] random groups");
    for (int g = 0; g < 20; g++) begin
      for (int i = 0; i < M; i++) begin
        rmet[i] = 12'($urandom_range(0, 4095));
        rb[i]   = 1'($urandom_range(0, 1));
      end
      applyStimulus(rmet, rb, M, 1'($urandom_range(0, 1)));
      checkResult($sformatf("rand%0d", g), model(rmet, rb), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
